// File: rtl/uart_tx_sched.sv
// Two-requester round-robin byte scheduler feeding a paced console sink through a FIFO.
// Optional feature macro UART_CRLF_EN: a popped LF (0x0A) is emitted as CR (0x0D) then LF.
module uart_tx_sched #(
  parameter int DEPTH = 16,
  parameter int PACE  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   a_valid,
  input  logic [7:0]             a_data,
  output logic                   a_ready,
  input  logic                   b_valid,
  input  logic [7:0]             b_data,
  output logic                   b_ready,
  output logic                   uart_we,
  output logic [31:0]            uart_wdata,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   busy
);

  localparam int         AW          = $clog2(DEPTH);
  localparam int         CW          = AW + 1;
  localparam logic [7:0] PACE_RELOAD = 8'(PACE - 1);

`ifdef UART_CRLF_EN
  typedef enum logic [1:0] {ST_IDLE, ST_EMIT, ST_WAIT, ST_CR} state_e;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_EMIT, ST_WAIT} state_e;
`endif

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          rr_q;                 // 0: A wins a tie, 1: B wins a tie
  state_e        state_q, state_d;
  logic [7:0]    pace_q, pace_d;
  logic          we_q, we_d;
  logic [7:0]    data_q, data_d;
  logic          full, empty, push_a, push_b, push, pop, launch_ok;
  logic [7:0]    push_data, head;
`ifdef UART_CRLF_EN
  logic          lf_pend_q, lf_pend_d;
`endif

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign a_ready   = !full && (!b_valid || !rr_q);
  assign b_ready   = !full && (!a_valid || rr_q);
  assign push_a    = a_valid && a_ready;
  assign push_b    = b_valid && b_ready;
  assign push      = push_a || push_b;
  assign push_data = push_a ? a_data : b_data;
  assign head      = mem_q[rd_ptr_q];

  // NOTE: the storage array has no reset; occupancy is tracked by count_q, so stale contents are never read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  // NOTE: every clocked block uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rr_q     <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
      if (push_a)      rr_q <= 1'b1;
      else if (push_b) rr_q <= 1'b0;
    end
  end

  // NOTE: all always_comb outputs get a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    pace_d    = pace_q;
    we_d      = 1'b0;
    data_d    = data_q;
    pop       = 1'b0;
    launch_ok = 1'b0;
`ifdef UART_CRLF_EN
    lf_pend_d = lf_pend_q;
`endif
    case (state_q)
      ST_IDLE: launch_ok = 1'b1;
      ST_EMIT: begin
        if (PACE == 1) begin
`ifdef UART_CRLF_EN
          state_d = lf_pend_q ? ST_CR : ST_IDLE;
`else
          state_d = ST_IDLE;
`endif
        end else begin
          pace_d  = PACE_RELOAD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        pace_d = pace_q - 8'd1;
        if (pace_q == 8'd1) begin
          // The last wait cycle may launch directly so backlog strobes land exactly PACE apart.
          state_d   = ST_IDLE;
          launch_ok = 1'b1;
        end
      end
`ifdef UART_CRLF_EN
      ST_CR:   launch_ok = 1'b1;
`endif
      default: state_d = ST_IDLE;
    endcase

    if (launch_ok) begin
`ifdef UART_CRLF_EN
      if (lf_pend_q) begin
        data_d    = 8'h0A;
        lf_pend_d = 1'b0;
        we_d      = 1'b1;
        state_d   = ST_EMIT;
      end else if (!empty) begin
        pop     = 1'b1;
        we_d    = 1'b1;
        state_d = ST_EMIT;
        if (head == 8'h0A) begin
          data_d    = 8'h0D;
          lf_pend_d = 1'b1;
        end else begin
          data_d = head;
        end
      end
`else
      if (!empty) begin
        pop     = 1'b1;
        we_d    = 1'b1;
        data_d  = head;
        state_d = ST_EMIT;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pace_q    <= '0;
      we_q      <= 1'b0;
      data_q    <= '0;
`ifdef UART_CRLF_EN
      lf_pend_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pace_q    <= pace_d;
      we_q      <= we_d;
      data_q    <= data_d;
`ifdef UART_CRLF_EN
      lf_pend_q <= lf_pend_d;
`endif
    end
  end

  assign uart_we    = we_q;
  assign uart_wdata = {24'h0, data_q};
  assign fifo_count = count_q;
  assign busy       = !empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomized bench for uart_tx_sched: two instances (PACE=4 and PACE=1) checked every cycle
// against a timestamp-based model of arbitration, FIFO order and strobe pacing.
module tb_uart_tx_sched;

  localparam int N     = 2;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_valid [N], b_valid [N], a_ready [N], b_ready [N];
  logic [7:0]    a_data [N], b_data [N];
  logic          uart_we [N], busy [N];
  logic [31:0]   uart_wdata [N];
  logic [CW-1:0] fifo_count [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    uart_tx_sched #(.DEPTH(DEPTH), .PACE((g == 0) ? 4 : 1)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a_valid   (a_valid[g]),
      .a_data    (a_data[g]),
      .a_ready   (a_ready[g]),
      .b_valid   (b_valid[g]),
      .b_data    (b_data[g]),
      .b_ready   (b_ready[g]),
      .uart_we   (uart_we[g]),
      .uart_wdata(uart_wdata[g]),
      .fifo_count(fifo_count[g]),
      .busy      (busy[g])
    );
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Requester r drives DUT r/2; even r is side A, odd r is side B.
  logic [7:0] src_q [2*N][$];
  bit         act [2*N];
  logic [7:0] cur [2*N];
  int         issue_pct   = 100;
  int         issue_limit = DEPTH + 1;

  // Reference model: byte queue, tie-break owner, time of last strobe launch.
  logic [7:0] mq [N][$];
  bit         m_rr [N];
  int         m_last [N];
  bit         m_pend [N];
  bit         m_we [N];
  bit         m_busy [N];
  logic [7:0] m_wdata [N];

  logic [7:0] sink_log [N][$];
  int         strobe_t [N][$];
  bit         full_seen [N];
  int         acc_t [N];
  int         cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pace_of(int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic int eff_pace(int d);
    return (pace_of(d) < 2) ? 2 : pace_of(d);
  endfunction

  function automatic bit all_idle();
    for (int r = 0; r < 2*N; r++) if (act[r] || src_q[r].size() != 0) return 1'b0;
    for (int d = 0; d < N; d++) if (m_busy[d]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < N; d++) begin
      mq[d].delete();
      m_rr[d]    = 1'b0;
      m_last[d]  = -1000;
      m_pend[d]  = 1'b0;
      m_we[d]    = 1'b0;
      m_busy[d]  = 1'b0;
      m_wdata[d] = 8'h00;
    end
  endtask

  task automatic clear_logs();
    for (int d = 0; d < N; d++) begin
      sink_log[d].delete();
      strobe_t[d].delete();
      full_seen[d] = 1'b0;
    end
  endtask

  // One clock cycle, entered and left at a negedge.
  task automatic step();
    bit       ga [N];
    bit       gb [N];
    bit       full;
    logic [7:0] b;
    for (int r = 0; r < 2*N; r++) begin
      if (!act[r] && src_q[r].size() > 0 && mq[r/2].size() < issue_limit &&
          $urandom_range(99) < issue_pct) begin
        act[r] = 1'b1;
        cur[r] = src_q[r].pop_front();
      end
    end
    for (int d = 0; d < N; d++) begin
      a_valid[d] = act[2*d];
      a_data[d]  = cur[2*d];
      b_valid[d] = act[2*d+1];
      b_data[d]  = cur[2*d+1];
    end
    #1;
    for (int d = 0; d < N; d++) begin
      full  = (mq[d].size() == DEPTH);
      ga[d] = act[2*d]   && !full && (!act[2*d+1] || !m_rr[d]);
      gb[d] = act[2*d+1] && !full && (!act[2*d]   ||  m_rr[d]);
      check($sformatf("grant_a[%0d]", d), 32'(a_valid[d] && a_ready[d]), 32'(ga[d]));
      check($sformatf("grant_b[%0d]", d), 32'(b_valid[d] && b_ready[d]), 32'(gb[d]));
      if (full) check($sformatf("rdy_full[%0d]", d), 32'({a_ready[d], b_ready[d]}), 32'(0));
      if ((m_pend[d] || mq[d].size() > 0) && (cyc - m_last[d] >= eff_pace(d))) begin
        m_we[d]   = 1'b1;
        m_last[d] = cyc;
        if (m_pend[d]) begin
          m_wdata[d] = 8'h0A;
          m_pend[d]  = 1'b0;
        end else begin
          b = mq[d].pop_front();
          m_wdata[d] = b;
`ifdef UART_CRLF_EN
          if (b == 8'h0A) begin
            m_wdata[d] = 8'h0D;
            m_pend[d]  = 1'b1;
          end
`endif
        end
      end else begin
        m_we[d] = 1'b0;
      end
      if (ga[d]) begin
        mq[d].push_back(cur[2*d]);
        m_rr[d]  = 1'b1;
        acc_t[d] = cyc;
      end
      if (gb[d]) begin
        mq[d].push_back(cur[2*d+1]);
        m_rr[d] = 1'b0;
      end
      m_busy[d] = (mq[d].size() > 0) || m_pend[d] || (cyc - m_last[d] < pace_of(d));
    end
    @(posedge clk);
    for (int d = 0; d < N; d++) begin
      if (ga[d]) act[2*d]   = 1'b0;
      if (gb[d]) act[2*d+1] = 1'b0;
    end
    cyc++;
    @(negedge clk);
    for (int d = 0; d < N; d++) begin
      check($sformatf("we[%0d]", d),    32'(uart_we[d]),    32'(m_we[d]));
      check($sformatf("wdata[%0d]", d), uart_wdata[d],      {24'h0, m_wdata[d]});
      check($sformatf("count[%0d]", d), 32'(fifo_count[d]), 32'(mq[d].size()));
      check($sformatf("busy[%0d]", d),  32'(busy[d]),       32'(m_busy[d]));
      if (uart_we[d]) begin
        sink_log[d].push_back(uart_wdata[d][7:0]);
        strobe_t[d].push_back(cyc - 1);
      end
      if (fifo_count[d] == CW'(DEPTH)) full_seen[d] = 1'b1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (!all_idle() && n < 3000) begin
      step();
      n++;
    end
    check("drain_done", 32'(all_idle()), 32'(1));
  endtask

  // Entered at a negedge; checks the asynchronous clear before any clock edge.
  task automatic do_reset();
    rst_n = 1'b0;
    for (int r = 0; r < 2*N; r++) begin
      act[r] = 1'b0;
      src_q[r].delete();
    end
    for (int d = 0; d < N; d++) begin
      a_valid[d] = 1'b0;
      b_valid[d] = 1'b0;
    end
    #1;
    for (int d = 0; d < N; d++) begin
      check($sformatf("rst_we[%0d]", d),    32'(uart_we[d]),    32'(0));
      check($sformatf("rst_count[%0d]", d), 32'(fifo_count[d]), 32'(0));
      check($sformatf("rst_busy[%0d]", d),  32'(busy[d]),       32'(0));
      check($sformatf("rst_wdata[%0d]", d), uart_wdata[d],      32'(0));
    end
    model_reset();
    repeat (2) @(negedge clk);
    cyc += 2;
    rst_n = 1'b1;
  endtask

  logic [7:0] exp_ab [4];
  logic [7:0] r8;
  int         n_lf;
  int         n;

  initial begin
    rst_n = 1'b1;
    for (int r = 0; r < 2*N; r++) cur[r] = 8'h00;
    for (int d = 0; d < N; d++) begin
      a_valid[d] = 1'b0; b_valid[d] = 1'b0; a_data[d] = 8'h00; b_data[d] = 8'h00;
    end
    model_reset();
    @(negedge clk);
    do_reset();
    step();

    // Both requesters valid continuously: grants alternate starting with A.
    clear_logs();
    for (int d = 0; d < N; d++)
      for (int i = 0; i < 4; i++) begin
        src_q[2*d].push_back(8'h41 + 8'(i));
        src_q[2*d+1].push_back(8'h61 + 8'(i));
      end
    drain();
    exp_ab[0] = 8'h41; exp_ab[1] = 8'h61; exp_ab[2] = 8'h42; exp_ab[3] = 8'h62;
    for (int d = 0; d < N; d++) begin
      check($sformatf("ab_n[%0d]", d), 32'(sink_log[d].size()), 32'(8));
      for (int i = 0; i < 4 && i < sink_log[d].size(); i++)
        check($sformatf("ab_order[%0d][%0d]", d, i), 32'(sink_log[d][i]), 32'(exp_ab[i]));
    end

    // Single byte: two-edge latency, then idle.
    clear_logs();
    for (int d = 0; d < N; d++) src_q[2*d].push_back(8'h48);
    drain();
    for (int d = 0; d < N; d++) begin
      check($sformatf("one_n[%0d]", d), 32'(sink_log[d].size()), 32'(1));
      if (sink_log[d].size() > 0) begin
        check($sformatf("one_data[%0d]", d), 32'(sink_log[d][0]), 32'h48);
        check($sformatf("one_lat[%0d]", d), 32'(strobe_t[d][0] + 1 - acc_t[d]), 32'(2));
      end
      check($sformatf("one_busy[%0d]", d), 32'(busy[d]), 32'(0));
    end

    // Line feed handling.
    clear_logs();
    for (int d = 0; d < N; d++) src_q[2*d].push_back(8'h0A);
    drain();
    for (int d = 0; d < N; d++) begin
`ifdef UART_CRLF_EN
      check($sformatf("lf_n[%0d]", d), 32'(sink_log[d].size()), 32'(2));
      if (sink_log[d].size() >= 2) begin
        check($sformatf("lf_cr[%0d]", d), 32'(sink_log[d][0]), 32'h0D);
        check($sformatf("lf_lf[%0d]", d), 32'(sink_log[d][1]), 32'h0A);
        check($sformatf("lf_gap[%0d]", d), 32'(strobe_t[d][1] - strobe_t[d][0]), 32'(eff_pace(d)));
      end
`else
      check($sformatf("lf_n[%0d]", d), 32'(sink_log[d].size()), 32'(1));
      if (sink_log[d].size() >= 1) check($sformatf("lf_lf[%0d]", d), 32'(sink_log[d][0]), 32'h0A);
`endif
    end

    // Saturate the FIFO from both sides; nothing may be dropped.
    clear_logs();
    for (int d = 0; d < N; d++) begin
      n_lf = 0;
      for (int i = 0; i < 48; i++) begin
        r8 = 8'($urandom);
        if (r8 == 8'h0A) n_lf++;
        src_q[2*d + (i % 2)].push_back(r8);
      end
      drain();
`ifdef UART_CRLF_EN
      check($sformatf("fill_n[%0d]", d), 32'(sink_log[d].size()), 32'(48 + n_lf));
`else
      check($sformatf("fill_n[%0d]", d), 32'(sink_log[d].size()), 32'(48));
`endif
      check($sformatf("fill_seen[%0d]", d), 32'(full_seen[d]), 32'(1));
    end

    // Burst under backlog: strobe spacing is exactly the effective pace.
    clear_logs();
    for (int d = 0; d < N; d++)
      for (int i = 0; i < 8; i++) src_q[2*d].push_back(8'h30 + 8'(i));
    drain();
    for (int d = 0; d < N; d++) begin
      check($sformatf("burst_n[%0d]", d), 32'(sink_log[d].size()), 32'(8));
      for (int i = 0; i < sink_log[d].size(); i++) begin
        check($sformatf("burst_data[%0d][%0d]", d, i), 32'(sink_log[d][i]), 32'h30 + 32'(i));
        if (i > 0)
          check($sformatf("burst_gap[%0d][%0d]", d, i), 32'(strobe_t[d][i] - strobe_t[d][i-1]),
                32'(eff_pace(d)));
      end
    end

    // Random traffic with idle gaps.
    clear_logs();
    issue_pct = 40;
    for (int r = 0; r < 2*N; r++)
      for (int i = 0; i < 40; i++) src_q[r].push_back(8'($urandom));
    drain();
    issue_pct = 100;

    // Reset while strobing with five bytes queued.
    clear_logs();
    issue_limit = 6;
    for (int d = 0; d < N; d++)
      for (int i = 0; i < 30; i++) src_q[2*d].push_back(8'h80 + 8'(i));
    n = 0;
    while (!(m_we[0] && mq[0].size() == 5) && n < 400) begin
      step();
      n++;
    end
    check("rst_pre_we", 32'(uart_we[0]), 32'(1));
    check("rst_pre_count", 32'(fifo_count[0]), 32'(5));
    do_reset();
    issue_limit = DEPTH + 1;
    clear_logs();
    repeat (30) step();
    for (int d = 0; d < N; d++)
      check($sformatf("rst_stale[%0d]", d), 32'(sink_log[d].size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
